// File: rtl/itch_msg_framer.sv
// ITCH message framer: splits a MoldUDP64 payload byte stream into
// length-prefixed message blocks and emits each body byte with start/end
// markers, type, index and length, one cycle after the input byte.
module itch_msg_framer #(
  parameter logic [15:0] MAX_MSG_LEN = 16'd64,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        itchDataValidIn,
  input  logic [7:0]  itchDataIn,
  output logic        msgValidOut,
  output logic [7:0]  msgDataOut,
  output logic        msgStartOut,
  output logic        msgEndOut,
  output logic [7:0]  msgTypeOut,
  output logic [15:0] msgIdxOut,
  output logic [15:0] msgLenOut,
  output logic        lenErrOut,
  output logic        abortOut,
  output logic [31:0] msgCntOut
);

  localparam int unsigned     GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    LEN_HI,
    LEN_LO,
    BODY,
    DISCARD
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [15:0]   remain_q, remain_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic [7:0]    type_q, type_d;
  logic [15:0]   idx_q, idx_d;
  logic [15:0]   len_q, len_d;
  logic          len_err_q, len_err_d;
  logic          abort_q, abort_d;
  logic [31:0]   cnt_q, cnt_d;

  logic [15:0]   len_w;

  assign len_w = {len_hi_q, itchDataIn};

  // Next-state and next-output computation for the block framing FSM.
  // len_q doubles as the current body length for index arithmetic: it is
  // loaded on a legal length and held until the next legal length.
  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    remain_d  = remain_q;
    gap_d     = gap_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    type_d    = type_q;
    idx_d     = idx_q;
    len_d     = len_q;
    len_err_d = 1'b0;
    abort_d   = 1'b0;
    cnt_d     = cnt_q;

    if (state_q == LEN_HI) begin
      // Inter-frame idle is legal: gap counter stays cleared.
      gap_d = '0;
      if (itchDataValidIn) begin
        len_hi_d = itchDataIn;
        state_d  = LEN_LO;
      end
    end else if (!itchDataValidIn) begin
      if (gap_q == GAP_LAST) begin
        abort_d = 1'b1;
        gap_d   = '0;
        state_d = LEN_HI;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end else begin
      // A byte always clears the gap, even on the cycle it would expire.
      gap_d = '0;
      unique case (state_q)
        LEN_LO: begin
          if (len_w == '0) begin
            len_err_d = 1'b1;
            state_d   = LEN_HI;
          end else if (len_w > MAX_MSG_LEN) begin
            len_err_d = 1'b1;
            remain_d  = len_w;
            state_d   = DISCARD;
          end else begin
            remain_d = len_w;
            len_d    = len_w;
            state_d  = BODY;
          end
        end
        BODY: begin
          valid_d = 1'b1;
          data_d  = itchDataIn;
          idx_d   = len_q - remain_q;
          if (remain_q == len_q) begin
            start_d = 1'b1;
            type_d  = itchDataIn;
          end
          if (remain_q == 16'd1) begin
            end_d   = 1'b1;
            cnt_d   = cnt_q + 32'd1;
            state_d = LEN_HI;
          end else begin
            remain_d = remain_q - 16'd1;
          end
        end
        DISCARD: begin
          if (remain_q == 16'd1) begin
            state_d = LEN_HI;
          end else begin
            remain_d = remain_q - 16'd1;
          end
        end
        default: state_d = LEN_HI;
      endcase
    end
  end

  // State and registered outputs; reset abandons any partial message.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q   <= LEN_HI;
      len_hi_q  <= '0;
      remain_q  <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      type_q    <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      remain_q  <= remain_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      start_q   <= start_d;
      end_q     <= end_d;
      type_q    <= type_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
      abort_q   <= abort_d;
      cnt_q     <= cnt_d;
    end
  end

  assign msgValidOut = valid_q;
  assign msgDataOut  = data_q;
  assign msgStartOut = start_q;
  assign msgEndOut   = end_q;
  assign msgTypeOut  = type_q;
  assign msgIdxOut   = idx_q;
  assign msgLenOut   = len_q;
  assign lenErrOut   = len_err_q;
  assign abortOut    = abort_q;
  assign msgCntOut   = cnt_q;

endmodule
